// File: rtl/run_command_sequencer_pkg.sv
// Shared definitions for the host command word and the acquisition run state.
// The USB controller imports this package to build command words, and
// run_command_sequencer imports it to decode them, so both sides agree on
// the op encodings and field positions.
//   Word layout: [15:14] op, [13:0] value.
package run_command_sequencer_pkg;

  localparam int CMD_W      = 16;
  localparam int CMD_OP_MSB = 15;
  localparam int CMD_OP_LSB = 14;
  localparam int CMD_VAL_W  = 14;

  localparam logic [1:0] CMD_NOOP       = 2'b00;
  localparam logic [1:0] CMD_START      = 2'b01;
  localparam logic [1:0] CMD_STOP       = 2'b10;
  localparam logic [1:0] CMD_SET_FRAMES = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2
  } seq_state_e;

  // Builds a command word from an op and a value (used by the encoder side).
  function automatic logic [CMD_W-1:0] cmd_encode(input logic [1:0] op,
                                                  input logic [CMD_VAL_W-1:0] value);
    return {op, value};
  endfunction

  // Frame counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/run_command_sequencer.sv
// run_command_sequencer
// Decodes host command words from the USB controller and owns the acquisition
// run state (running flag, integration length, frame limit, graceful stop at a
// frame boundary with a timeout fallback).
// Ports:
//   clk_in                   in   system clock
//   reset_n                  in   asynchronous active-low reset
//   cmd_word[15:0]           in   command word, sampled when cmd_valid=1
//   cmd_valid                in   one-cycle strobe per command
//   frame_done               in   end-of-frame pulse from the readout controller
//   running                  out  readout enable
//   integration_clock_count  out  integration length in clk_in cycles
//   frame_count[15:0]        out  frames completed in the current run (saturating)
//   cmd_ack                  out  one-cycle pulse, command accepted
//   cmd_error                out  one-cycle pulse, command rejected
//   stop_forced              out  sticky, set when a stop had to time out
module run_command_sequencer
  import run_command_sequencer_pkg::*;
#(
  parameter int unsigned DEFAULT_INTG_COUNT = 5000,
  parameter int unsigned INTG_SHIFT         = 2,
  parameter int unsigned STOP_TIMEOUT       = 65535
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [CMD_W-1:0]  cmd_word,
  input  logic              cmd_valid,
  input  logic              frame_done,
  output logic              running,
  output logic [31:0]       integration_clock_count,
  output logic [15:0]       frame_count,
  output logic              cmd_ack,
  output logic              cmd_error,
  output logic              stop_forced
);

  localparam int TIMER_W = $clog2(STOP_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STOP_TIMEOUT - 1);

  seq_state_e             state_q, state_d;
  logic                   running_q, running_d;
  logic [31:0]            intg_q, intg_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic [CMD_VAL_W-1:0]   frame_limit_q, frame_limit_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic                   stop_forced_q, stop_forced_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;

  logic [1:0]             cmd_op;
  logic [CMD_VAL_W-1:0]   cmd_val;
  logic [15:0]            frame_inc;
  logic                   limit_hit;
  logic                   timeout_hit;
  logic                   start_ok;
  logic                   cmd_reject;

  // Command decode and shared conditions. START and SET_FRAMES are only
  // legal in IDLE (run parameters are frozen once a run begins), and a START
  // with a zero integration value is always rejected.
  always_comb begin
    cmd_op      = cmd_word[CMD_OP_MSB:CMD_OP_LSB];
    cmd_val     = cmd_word[CMD_VAL_W-1:0];
    frame_inc   = sat_inc16(frame_count_q);
    limit_hit   = frame_done && (frame_limit_q != '0) &&
                  (frame_inc == {{(16-CMD_VAL_W){1'b0}}, frame_limit_q});
    timeout_hit = (timer_q == TIMER_LAST) && !frame_done;
    start_ok    = cmd_valid && (state_q == ST_IDLE) &&
                  (cmd_op == CMD_START) && (cmd_val != '0);
    cmd_reject  = cmd_valid &&
                  (((cmd_op == CMD_START) && ((state_q != ST_IDLE) || (cmd_val == '0))) ||
                   ((cmd_op == CMD_SET_FRAMES) && (state_q != ST_IDLE)));
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Reaching the frame limit wins over a simultaneous STOP,
  // since the run is already over at that frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (limit_hit) begin
          state_d = ST_IDLE;
        end else if (cmd_valid && (cmd_op == CMD_STOP)) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (frame_done || timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and run parameters. running simply
  // follows the next state, so it drops on the same edge the FSM returns to
  // IDLE. The stop timer only advances while staying in STOPPING.
  always_comb begin
    running_d     = (state_d != ST_IDLE);
    intg_d        = intg_q;
    frame_count_d = frame_count_q;
    frame_limit_d = frame_limit_q;
    stop_forced_d = stop_forced_q;
    ack_d         = cmd_valid && !cmd_reject;
    err_d         = cmd_reject;
    timer_d       = '0;

    if (start_ok) begin
      intg_d        = 32'(cmd_val) << INTG_SHIFT;
      frame_count_d = '0;
      stop_forced_d = 1'b0;
    end

    if ((state_q != ST_IDLE) && frame_done) begin
      frame_count_d = frame_inc;
    end

    if (cmd_valid && (state_q == ST_IDLE) && (cmd_op == CMD_SET_FRAMES)) begin
      frame_limit_d = cmd_val;
    end

    if ((state_q == ST_STOPPING) && timeout_hit) begin
      stop_forced_d = 1'b1;
    end

    if ((state_q == ST_STOPPING) && (state_d == ST_STOPPING)) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      running_q     <= 1'b0;
      intg_q        <= 32'(DEFAULT_INTG_COUNT);
      frame_count_q <= '0;
      frame_limit_q <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      stop_forced_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      running_q     <= running_d;
      intg_q        <= intg_d;
      frame_count_q <= frame_count_d;
      frame_limit_q <= frame_limit_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      stop_forced_q <= stop_forced_d;
      timer_q       <= timer_d;
    end
  end

  assign running                 = running_q;
  assign integration_clock_count = intg_q;
  assign frame_count             = frame_count_q;
  assign cmd_ack                 = ack_q;
  assign cmd_error               = err_q;
  assign stop_forced             = stop_forced_q;

endmodule

// File: tb/tb_run_command_sequencer.sv
// Testbench for run_command_sequencer. Commands push their expected response
// into a queue; a monitor pops and compares whenever the DUT pulses cmd_ack or
// cmd_error. A second instance with a short stop timeout covers forced stops.
module tb_run_command_sequencer;
  import run_command_sequencer_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic        frame_done;
  logic        running;
  logic [31:0] integration_clock_count;
  logic [15:0] frame_count;
  logic        cmd_ack;
  logic        cmd_error;
  logic        stop_forced;

  logic [15:0] t_cmd_word   = '0;
  logic        t_cmd_valid  = 1'b0;
  logic        t_frame_done = 1'b0;
  logic        t_running;
  logic [31:0] t_intg;
  logic [15:0] t_frame_count;
  logic        t_cmd_ack;
  logic        t_cmd_error;
  logic        t_stop_forced;

  typedef struct {
    logic        ack;
    logic        run;
    logic [31:0] intg;
    logic [15:0] fc;
    logic        sf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  logic run_dropped;

  always #5 clk_in = ~clk_in;

  run_command_sequencer #(.STOP_TIMEOUT(64)) u_dut (
    .clk_in                  (clk_in),
    .reset_n                 (reset_n),
    .cmd_word                (cmd_word),
    .cmd_valid               (cmd_valid),
    .frame_done              (frame_done),
    .running                 (running),
    .integration_clock_count (integration_clock_count),
    .frame_count             (frame_count),
    .cmd_ack                 (cmd_ack),
    .cmd_error               (cmd_error),
    .stop_forced             (stop_forced)
  );

  run_command_sequencer #(.STOP_TIMEOUT(16)) u_dut_to (
    .clk_in                  (clk_in),
    .reset_n                 (reset_n),
    .cmd_word                (t_cmd_word),
    .cmd_valid               (t_cmd_valid),
    .frame_done              (t_frame_done),
    .running                 (t_running),
    .integration_clock_count (t_intg),
    .frame_count             (t_frame_count),
    .cmd_ack                 (t_cmd_ack),
    .cmd_error               (t_cmd_error),
    .stop_forced             (t_stop_forced)
  );

  // Single comparison point shared by the monitor and the directed checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Queue the expected response, then hold the command for one clock edge.
  // Back-to-back calls keep cmd_valid high across consecutive cycles.
  task automatic applyStimulus(input logic [1:0] op, input logic [13:0] val,
                               input logic fd, input logic e_ack, input logic e_run,
                               input logic [31:0] e_intg, input logic [15:0] e_fc,
                               input logic e_sf);
    exp_t e;
    e.ack = e_ack; e.run = e_run; e.intg = e_intg; e.fc = e_fc; e.sf = e_sf;
    exp_q.push_back(e);
    cmd_word   = cmd_encode(op, val);
    cmd_valid  = 1'b1;
    frame_done = fd;
    @(posedge clk_in); #1;
    cmd_valid  = 1'b0;
    frame_done = 1'b0;
  endtask

  // One clock edge with no command, optionally with a frame_done pulse.
  task automatic tick(input logic fd);
    frame_done = fd;
    @(posedge clk_in); #1;
    frame_done = 1'b0;
  endtask

  // Drives one command into the short-timeout instance.
  task automatic toCommand(input logic [1:0] op, input logic [13:0] val);
    t_cmd_word  = cmd_encode(op, val);
    t_cmd_valid = 1'b1;
    @(posedge clk_in); #1;
    t_cmd_valid = 1'b0;
  endtask

  // Monitor: every response pulse must match the oldest queued expectation.
  always @(negedge clk_in) begin
    if (reset_n && (cmd_ack || cmd_error)) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_response: got ack=%0b err=%0b, required no pulse",
                 cmd_ack, cmd_error);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("resp_ack",   {31'b0, cmd_ack},     {31'b0, mon_e.ack});
        checkOutput("resp_error", {31'b0, cmd_error},   {31'b0, !mon_e.ack});
        checkOutput("resp_running", {31'b0, running},   {31'b0, mon_e.run});
        checkOutput("resp_intg", integration_clock_count, mon_e.intg);
        checkOutput("resp_frame_count", {16'b0, frame_count}, {16'b0, mon_e.fc});
        checkOutput("resp_stop_forced", {31'b0, stop_forced}, {31'b0, mon_e.sf});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    cmd_word   = '0;
    cmd_valid  = 1'b0;
    frame_done = 1'b0;
    #23 reset_n = 1'b1;
    @(posedge clk_in); #1;

    // Reset state, and no spontaneous pulses.
    checkOutput("reset_running", {31'b0, running}, 32'd0);
    checkOutput("reset_intg", integration_clock_count, 32'd5000);
    checkOutput("reset_frame_count", {16'b0, frame_count}, 32'd0);
    checkOutput("reset_stop_forced", {31'b0, stop_forced}, 32'd0);
    tick(1'b0); tick(1'b0); tick(1'b0);
    checkOutput("reset_no_ack", {31'b0, cmd_ack}, 32'd0);
    checkOutput("reset_no_error", {31'b0, cmd_error}, 32'd0);

    // START 100 -> 400 cycles, then three frames.
    applyStimulus(CMD_START, 14'd100, 1'b0, 1'b1, 1'b1, 32'd400, 16'd0, 1'b0);
    tick(1'b1); tick(1'b1); tick(1'b1);
    checkOutput("frames_after_3", {16'b0, frame_count}, 32'd3);
    checkOutput("running_after_3", {31'b0, running}, 32'd1);

    // Graceful stop: running held until the frame boundary 50 cycles later.
    applyStimulus(CMD_STOP, 14'd0, 1'b0, 1'b1, 1'b1, 32'd400, 16'd3, 1'b0);
    run_dropped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      if (!running) run_dropped = 1'b1;
    end
    applyStimulus(CMD_START, 14'd7, 1'b0, 1'b0, 1'b1, 32'd400, 16'd3, 1'b0);
    for (int i = 0; i < 38; i++) begin
      tick(1'b0);
      if (!running) run_dropped = 1'b1;
    end
    checkOutput("stopping_running_held", {31'b0, run_dropped}, 32'd0);
    applyStimulus(CMD_NOOP, 14'd0, 1'b1, 1'b1, 1'b0, 32'd400, 16'd4, 1'b0);
    checkOutput("graceful_no_force", {31'b0, stop_forced}, 32'd0);

    // START with zero value is rejected in IDLE.
    applyStimulus(CMD_START, 14'd0, 1'b0, 1'b0, 1'b0, 32'd400, 16'd4, 1'b0);

    // Frame limit 2, START 10; SET_FRAMES while running is rejected.
    applyStimulus(CMD_SET_FRAMES, 14'd2, 1'b0, 1'b1, 1'b0, 32'd400, 16'd4, 1'b0);
    applyStimulus(CMD_START, 14'd10, 1'b0, 1'b1, 1'b1, 32'd40, 16'd0, 1'b0);
    applyStimulus(CMD_SET_FRAMES, 14'd5, 1'b0, 1'b0, 1'b1, 32'd40, 16'd0, 1'b0);
    tick(1'b1);
    checkOutput("limit_frame1_running", {31'b0, running}, 32'd1);
    tick(1'b1);
    checkOutput("limit_reached_running", {31'b0, running}, 32'd0);
    checkOutput("limit_reached_count", {16'b0, frame_count}, 32'd2);
    tick(1'b1);
    checkOutput("idle_frame_ignored", {16'b0, frame_count}, 32'd2);

    // STOP together with the frame that hits the limit: ends immediately.
    applyStimulus(CMD_SET_FRAMES, 14'd3, 1'b0, 1'b1, 1'b0, 32'd40, 16'd2, 1'b0);
    applyStimulus(CMD_START, 14'd5, 1'b0, 1'b1, 1'b1, 32'd20, 16'd0, 1'b0);
    tick(1'b1); tick(1'b1);
    applyStimulus(CMD_STOP, 14'd0, 1'b1, 1'b1, 1'b0, 32'd20, 16'd3, 1'b0);

    // STOP together with a frame below the limit: counted, then STOPPING.
    // These commands run back to back with cmd_valid held high.
    applyStimulus(CMD_SET_FRAMES, 14'd0, 1'b0, 1'b1, 1'b0, 32'd20, 16'd3, 1'b0);
    applyStimulus(CMD_START, 14'd7, 1'b0, 1'b1, 1'b1, 32'd28, 16'd0, 1'b0);
    applyStimulus(CMD_STOP, 14'd0, 1'b1, 1'b1, 1'b1, 32'd28, 16'd1, 1'b0);
    applyStimulus(CMD_STOP, 14'd0, 1'b0, 1'b1, 1'b1, 32'd28, 16'd1, 1'b0);
    applyStimulus(CMD_SET_FRAMES, 14'd4, 1'b0, 1'b0, 1'b1, 32'd28, 16'd1, 1'b0);
    applyStimulus(CMD_NOOP, 14'd0, 1'b1, 1'b1, 1'b0, 32'd28, 16'd2, 1'b0);
    applyStimulus(CMD_NOOP, 14'd0, 1'b0, 1'b1, 1'b0, 32'd28, 16'd2, 1'b0);
    applyStimulus(CMD_STOP, 14'd0, 1'b0, 1'b1, 1'b0, 32'd28, 16'd2, 1'b0);
    tick(1'b0); tick(1'b0);

    // Forced stop on the short-timeout instance, then a START clears it.
    toCommand(CMD_START, 14'd1);
    checkOutput("to_start_ack", {31'b0, t_cmd_ack}, 32'd1);
    checkOutput("to_start_running", {31'b0, t_running}, 32'd1);
    toCommand(CMD_STOP, 14'd0);
    checkOutput("to_stop_ack", {31'b0, t_cmd_ack}, 32'd1);
    repeat (15) begin
      @(posedge clk_in); #1;
    end
    checkOutput("to_before_timeout", {31'b0, t_running}, 32'd1);
    @(posedge clk_in); #1;
    checkOutput("to_timeout_running", {31'b0, t_running}, 32'd0);
    checkOutput("to_timeout_forced", {31'b0, t_stop_forced}, 32'd1);
    toCommand(CMD_START, 14'd2);
    checkOutput("to_restart_forced", {31'b0, t_stop_forced}, 32'd0);
    checkOutput("to_restart_running", {31'b0, t_running}, 32'd1);
    checkOutput("to_restart_intg", t_intg, 32'd8);

    // Asynchronous reset mid-run drops running without waiting for a clock.
    applyStimulus(CMD_START, 14'd1, 1'b0, 1'b1, 1'b1, 32'd4, 16'd0, 1'b0);
    tick(1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_running", {31'b0, running}, 32'd0);
    checkOutput("async_reset_intg", integration_clock_count, 32'd5000);
    #10 reset_n = 1'b1;
    @(posedge clk_in); #1;

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
